// File: rtl/calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_pkg                                                           |
// | Shared encodings, FSM states and 7-segment glyphs for calc_display |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        CONV = 2'b10,
        DONE = 2'b11
    } state_e;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] c_SEG_0     = 7'b1000000;
    localparam logic [6:0] c_SEG_1     = 7'b1111001;
    localparam logic [6:0] c_SEG_2     = 7'b0100100;
    localparam logic [6:0] c_SEG_3     = 7'b0110000;
    localparam logic [6:0] c_SEG_4     = 7'b0011001;
    localparam logic [6:0] c_SEG_5     = 7'b0010010;
    localparam logic [6:0] c_SEG_6     = 7'b0000010;
    localparam logic [6:0] c_SEG_7     = 7'b1111000;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0010000;
    localparam logic [6:0] c_SEG_A     = 7'b0001000;
    localparam logic [6:0] c_SEG_B     = 7'b0000011;
    localparam logic [6:0] c_SEG_C     = 7'b1000110;
    localparam logic [6:0] c_SEG_D     = 7'b0100001;
    localparam logic [6:0] c_SEG_E     = 7'b0000110;
    localparam logic [6:0] c_SEG_F     = 7'b0001110;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] c_SEG_MINUS = 7'b0111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] i_nib);
        logic [6:0] w_seg;
        case (i_nib)
            4'h0:    w_seg = c_SEG_0;
            4'h1:    w_seg = c_SEG_1;
            4'h2:    w_seg = c_SEG_2;
            4'h3:    w_seg = c_SEG_3;
            4'h4:    w_seg = c_SEG_4;
            4'h5:    w_seg = c_SEG_5;
            4'h6:    w_seg = c_SEG_6;
            4'h7:    w_seg = c_SEG_7;
            4'h8:    w_seg = c_SEG_8;
            4'h9:    w_seg = c_SEG_9;
            4'hA:    w_seg = c_SEG_A;
            4'hB:    w_seg = c_SEG_B;
            4'hC:    w_seg = c_SEG_C;
            4'hD:    w_seg = c_SEG_D;
            4'hE:    w_seg = c_SEG_E;
            default: w_seg = c_SEG_F;
        endcase
        return w_seg;
    endfunction

    // ceil(w * log10(2)): decimal digits needed for the largest w-bit value
    function automatic int dec_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_if                                                            |
// | Operand/command and result/status bundle for calc_display_top      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface calc_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             op_type;
    logic             dec_mode;
    logic             start;
    logic             clear_ovf;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;

    modport master (
        output a, b, op, op_type, dec_mode, start, clear_ovf,
        input  busy, done, result, overflow
    );

    modport slave (
        input  a, b, op, op_type, dec_mode, start, clear_ovf,
        output busy, done, result, overflow
    );
endinterface
`default_nettype wire

// File: rtl/digit_scan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | digit_scan                                                         |
// | Time-multiplexes a packed glyph vector onto anodes and cathodes    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module digit_scan
    import calc_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int REFRESH_BITS = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS*7-1:0]   i_glyphs,
    output logic [DIGITS-1:0]     activate,
    output logic [6:0]            LED_output
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [REFRESH_BITS-1:0] r_cnt;
    logic [IDXW-1:0]         r_idx;
    logic [IDXW-1:0]         w_idx_next;
    logic [DIGITS-1:0]       r_act;
    logic [6:0]              r_led;

    always_comb begin
        w_idx_next = r_idx;
        if (&r_cnt) begin
            w_idx_next = (r_idx == IDXW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    // Anode and cathode both follow the upcoming index so they switch together
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_act <= ~DIGITS'(1);
            r_led <= c_SEG_0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            r_idx <= w_idx_next;
            r_act <= ~(DIGITS'(1) << w_idx_next);
            r_led <= i_glyphs[32'(w_idx_next) * 7 +: 7];
        end
    end

    assign activate   = r_act;
    assign LED_output = r_led;

endmodule
`default_nettype wire

// File: rtl/calc_display_top.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_display_top                                                   |
// | ALU + sticky overflow + double-dabble BCD + multiplexed display    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module calc_display_top
    import calc_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DIGITS       = 4,
    parameter int REFRESH_BITS = 18
) (
    input  logic              clk,
    input  logic              reset,
    calc_if.slave             bus,
    output logic [DIGITS-1:0] activate,
    output logic [6:0]        LED_output
);

    localparam int NBCD = dec_digits(WIDTH);
    localparam int BCDW = 4 * NBCD;
    localparam int NHEX = WIDTH / 4;
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam logic [DIGITS*7-1:0] c_GLYPH_RESET = {{(DIGITS-1){c_SEG_BLANK}}, c_SEG_0};

    if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 16) begin : g_width_check
        $error("calc_display_top: WIDTH must be a multiple of 4 in 4..16");
    end
    if (DIGITS < NBCD + 1) begin : g_digits_check
        $error("calc_display_top: DIGITS too small for WIDTH plus sign");
    end

    state_e                 r_state;
    state_e                 w_state_next;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    op_e                    r_op;
    logic                   r_type;
    logic                   r_dec;
    logic [WIDTH-1:0]       r_result;
    logic                   r_ovf;
    logic                   r_done;
    logic [CNTW-1:0]        r_cnt;
    logic [BCDW+WIDTH-1:0]  r_conv;
    logic [DIGITS*7-1:0]    r_glyphs;

    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_diff;
    logic [WIDTH-1:0]       w_alu;
    logic                   w_ovf;
    logic [WIDTH-1:0]       w_mag;
    logic [BCDW+WIDTH-1:0]  w_adj;
    logic [BCDW+WIDTH-1:0]  w_dd_next;
    logic [BCDW-1:0]        w_bcd;
    logic                   w_neg;
    logic                   w_seen;
    logic [DIGITS*7-1:0]    w_glyphs;

    // ---------------- ALU ----------------
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_alu = '0;
        w_ovf = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_alu = w_sum[WIDTH-1:0];
                w_ovf = r_type ? ((r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]))
                               : w_sum[WIDTH];
            end
            OP_SUB: begin
                w_alu = w_diff[WIDTH-1:0];
                w_ovf = r_type ? ((r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]))
                               : w_diff[WIDTH];
            end
            OP_AND: w_alu = r_a & r_b;
            default: w_alu = r_a | r_b;
        endcase
    end

    // Two's-complement negate also maps the most-negative value to 2^(WIDTH-1)
    assign w_mag = (r_type && w_alu[WIDTH-1]) ? (~w_alu + 1'b1) : w_alu;

    // ---------------- Double-dabble step ----------------
    always_comb begin
        w_adj = r_conv;
        for (int i = 0; i < NBCD; i++) begin
            if (r_conv[WIDTH + 4*i +: 4] >= 4'd5) begin
                w_adj[WIDTH + 4*i +: 4] = r_conv[WIDTH + 4*i +: 4] + 4'd3;
            end
        end
        w_dd_next = w_adj << 1;
    end

    // ---------------- Glyph builder ----------------
    assign w_bcd = r_conv[BCDW+WIDTH-1 -: BCDW];
    assign w_neg = r_type && r_result[WIDTH-1];

    always_comb begin
        w_glyphs = {DIGITS{c_SEG_BLANK}};
        w_seen   = 1'b0;
        if (r_dec) begin
            for (int i = NBCD - 1; i >= 0; i--) begin
                if (w_bcd[4*i +: 4] != 4'd0 || i == 0) begin
                    w_seen = 1'b1;
                end
                if (w_seen) begin
                    w_glyphs[7*i +: 7] = seg_decode(w_bcd[4*i +: 4]);
                end
            end
            if (w_neg) begin
                w_glyphs[7*(DIGITS-1) +: 7] = c_SEG_MINUS;
            end
        end else begin
            for (int i = 0; i < NHEX; i++) begin
                w_glyphs[7*i +: 7] = seg_decode(r_result[4*i +: 4]);
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = EXEC;
            EXEC:    w_state_next = CONV;
            CONV:    if (r_cnt == CNTW'(WIDTH - 1)) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ADD;
            r_type   <= 1'b0;
            r_dec    <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_conv   <= '0;
            r_glyphs <= c_GLYPH_RESET;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a    <= bus.a;
                        r_b    <= bus.b;
                        r_op   <= op_e'(bus.op);
                        r_type <= bus.op_type;
                        r_dec  <= bus.dec_mode;
                    end
                end
                EXEC: begin
                    r_result <= w_alu;
                    r_conv   <= {{BCDW{1'b0}}, w_mag};
                    r_cnt    <= '0;
                end
                CONV: begin
                    r_conv <= w_dd_next;
                    r_cnt  <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_glyphs <= w_glyphs;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
            // A new overflow outranks a simultaneous clear request
            if (r_state == EXEC && w_ovf) begin
                r_ovf <= 1'b1;
            end else if (bus.clear_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.overflow = r_ovf;

    digit_scan #(
        .DIGITS       (DIGITS),
        .REFRESH_BITS (REFRESH_BITS)
    ) u_scan (
        .clk        (clk),
        .reset      (reset),
        .i_glyphs   (r_glyphs),
        .activate   (activate),
        .LED_output (LED_output)
    );

endmodule
`default_nettype wire

// File: tb/tb_calc_display_top.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_calc_display_top                                                |
// | Directed vectors with a done-triggered scoreboard monitor          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_calc_display_top;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int RB = 2;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MN = 7'b0111111;

    typedef struct {
        logic [W-1:0]   res;
        logic           ovf;
        logic [7*D-1:0] disp;
        int             done_cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [D-1:0]   activate;
    logic [6:0]     LED_output;

    exp_t q[$];
    int   n_vec    = 0;
    int   n_bad    = 0;
    int   n_done   = 0;
    int   cyc      = 0;
    bit   mon_busy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    calc_if #(.WIDTH(W)) bus ();

    calc_display_top #(
        .WIDTH        (W),
        .DIGITS       (D),
        .REFRESH_BITS (RB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .activate   (activate),
        .LED_output (LED_output)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: on every done pulse pop the expectation and check result, flags and scanned digits
    initial begin : monitor
        exp_t           e;
        logic [7*D-1:0] disp;
        logic [D-1:0]   oh;
        int             idx;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                mon_busy = 1'b1;
                n_done++;
                if (q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1, expected none (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("busy_at_done", {31'b0, bus.busy}, 32'd0);
                    check("result", {24'b0, bus.result}, {24'b0, e.res});
                    check("overflow", {31'b0, bus.overflow}, {31'b0, e.ovf});
                    @(negedge clk);
                    check("done_width", {31'b0, bus.done}, 32'd0);
                    disp = 'x;
                    for (int i = 0; i < 16; i++) begin
                        @(negedge clk);
                        idx = -1;
                        for (int j = 0; j < D; j++) begin
                            oh = D'(1) << j;
                            if (activate === ~oh) idx = j;
                        end
                        if (idx >= 0) disp[7*idx +: 7] = LED_output;
                    end
                    check("display", {4'b0, disp}, {4'b0, e.disp});
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                          input logic t, input logic dm, input bit clr_exec, input bit push,
                          input logic [W-1:0] er, input logic eo, input logic [7*D-1:0] ed);
        exp_t e;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.op = op; bus.op_type = t; bus.dec_mode = dm;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e.res = er; e.ovf = eo; e.disp = ed; e.done_cyc = cyc + 10;
            q.push_back(e);
        end
        check("busy_after_start", {31'b0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = ~a;
        bus.b = a ^ b;
        bus.op = ~op;
        bus.clear_ovf = clr_exec;
        @(negedge clk);
        bus.clear_ovf = 1'b0;
        @(posedge clk);
        #1;
        check("result_at_k2", {24'b0, bus.result}, {24'b0, er});
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((q.size() != 0 || mon_busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_idle: got timeout after %0d cycles, expected done", t);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear_ovf = 1'b1;
        @(negedge clk);
        bus.clear_ovf = 1'b0;
        check("ovf_cleared", {31'b0, bus.overflow}, 32'd0);
    endtask

    initial begin : driver
        logic [D-1:0] exp_act;
        int           base;
        bus.a = '0; bus.b = '0; bus.op = 2'b00; bus.op_type = 1'b0;
        bus.dec_mode = 1'b0; bus.start = 1'b0; bus.clear_ovf = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset values and digit scan with a 4-cycle dwell per digit
        check("rst_result", {24'b0, bus.result}, 32'd0);
        check("rst_overflow", {31'b0, bus.overflow}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            exp_act = ~(D'(1) << ((i / 4) % D));
            check("scan", {21'b0, activate, LED_output},
                  {21'b0, exp_act, (((i / 4) % D) == 0) ? G0 : BL});
            @(negedge clk);
        end

        run_op(8'hC8, 8'h64, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h2C, 1'b1, {BL, BL, G4, G4});
        wait_idle();
        pulse_clear();
        run_op(8'h05, 8'h0A, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFB, 1'b0, {MN, BL, BL, G5});
        wait_idle();
        // clear_ovf in the overflowing EXEC cycle must lose to the set
        run_op(8'h7F, 8'h01, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, {MN, G1, G2, G8});
        wait_idle();
        pulse_clear();
        run_op(8'hF0, 8'h3C, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 8'h30, 1'b0, {BL, BL, G3, G0});
        wait_idle();

        // Second start during CONV is ignored
        base = n_done;
        run_op(8'h12, 8'h21, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, {BL, BL, G5, G1});
        @(negedge clk);
        bus.a = 8'hFF; bus.b = 8'hFF; bus.op = 2'b00; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        check("single_done", n_done - base, 32'd1);

        run_op(8'h00, 8'h01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, {BL, BL, GF, GF});
        wait_idle();
        run_op(8'h03, 8'h05, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFE, 1'b1, {BL, G2, G5, G4});
        wait_idle();
        // Zero result, overflow still sticky from the borrow above
        run_op(8'h0F, 8'hF0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, {BL, BL, BL, G0});
        wait_idle();

        // Reset during CONV aborts without a done
        base = n_done;
        run_op(8'hF0, 8'h20, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 1'b1, {BL, BL, G1, G6_dummy()});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_result", {24'b0, bus.result}, 32'd0);
        check("abort_overflow", {31'b0, bus.overflow}, 32'd0);
        check("abort_display", {21'b0, activate, LED_output}, {21'b0, 4'b1110, G0});
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_no_done", n_done - base, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    function automatic logic [6:0] G6_dummy();
        return BL;
    endfunction

endmodule
`default_nettype wire

// File: doc/calc_display_top.md
# calc_display_top

Parametrised successor to the 4-bit calculator/display top level. It registers a WIDTH-bit ALU operation on a start pulse and tracks a sticky overflow flag. It converts the result to BCD sequentially (double-dabble) and drives a DIGITS-wide multiplexed 7-segment display in hex or signed/unsigned decimal. It sits between the board switches/buttons and the seven-segment anodes/cathodes.

## Interface
- WIDTH, 8, operand/result width; multiple of 4, range 4..16
- DIGITS, 4, display digits; elaboration error if DIGITS < ceil(WIDTH*log10(2)) + 1
- REFRESH_BITS, 18, scan prescaler width; digit advances every 2^REFRESH_BITS cycles
- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high
- a, b  in  WIDTH  operands
- op  in  2  00 ADD, 01 SUB (a-b), 10 AND, 11 OR
- type  in  1  1 = two's-complement signed, 0 = unsigned
- dec_mode  in  1  1 = decimal display, 0 = hex display
- start  in  1  single-cycle request; sampled only in IDLE
- clear_ovf  in  1  clears sticky overflow
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when result and display digits update
- result  out  WIDTH  registered ALU result
- overflow  out  1  sticky overflow flag
- activate  out  DIGITS  digit enables, active-low, one-hot-low
- LED_output  out  7  segments {g,f,e,d,c,b,a}, active-low

## Operation
- FSM states: IDLE, EXEC, CONV, DONE.
- **IDLE:** on `start`, latch a, b, op, type and dec_mode; go to EXEC.
- **EXEC:** compute the WIDTH-bit result and register it. Load the conversion register with the magnitude. Go to CONV.
- **CONV:** run WIDTH double-dabble iterations, one per cycle (add 3 to each BCD nibble >= 5, then shift left). Go to DONE.
- **DONE:** latch the display digits, pulse `done`, return to IDLE.
- Magnitude:
  - If type=1 and result[WIDTH-1]=1, the magnitude is -result, taken as unsigned WIDTH bits. The most-negative value yields 2^(WIDTH-1).
  - Otherwise the magnitude is the result.
- Overflow, evaluated in EXEC:
  - Unsigned ADD: carry out.
  - Unsigned SUB: borrow (a < b).
  - Signed ADD/SUB: operand signs agree (ADD) or differ (SUB), and the result sign differs from a.
  - AND/OR: never overflow.
- Sticky `overflow`:
  - Set in the EXEC cycle.
  - Cleared by `clear_ovf`.
  - If set and clear coincide, set wins.
- Hex display: digits 0..WIDTH/4-1 show result nibbles, glyphs 0-F. Higher digits are blank. No leading-zero blanking.
- Decimal display:
  - Digits show BCD with leading zeros blanked; digit 0 is always shown.
  - If type=1 and the result is negative, digit DIGITS-1 shows minus (segment g only).
- The display keeps showing the previous digits until DONE.
- `start` while busy is ignored; there is no queueing.

## Timing
- Reset values:
  - State IDLE.
  - result=0, overflow=0, busy=0, done=0.
  - Display digits: digit 0 = "0", others blank.
  - Scan counter 0, digit index 0.
  - activate = ~1 (digit 0 enabled), LED_output = 7'b1000000.
- Latency, with `start` sampled at edge k:
  - busy=1 from the cycle after k.
  - `result` valid from edge k+2.
  - `done` high for exactly the one cycle following edge k+WIDTH+2, i.e. 10 cycles for WIDTH=8.
  - busy=0 in that same cycle.
- A new start is accepted the cycle after `done`.
- Reset mid-operation:
  - Return to IDLE next edge; result/overflow/digits return to reset values.
  - No `done` pulse for the aborted operation.
- Scan:
  - REFRESH_BITS counter free-runs.
  - On wrap, digit index increments modulo DIGITS.
  - activate and LED_output are registered, so they change on the same edge with no glitch between digits.
- Operand inputs may change freely after the start edge.

## Structure
- Shared package `calc_pkg`:
  - op encodings.
  - FSM state enum.
  - 7-segment glyph constants: hex 0-F, BLANK = 7'b1111111, MINUS = 7'b0111111.
  - Function `seg_decode(4-bit)`.
- Sub-module `digit_scan` #(DIGITS, REFRESH_BITS):
  - Inputs: clk, reset, and the packed per-digit glyph vector.
  - Outputs: activate, LED_output.
- The top holds the ALU, FSM and double-dabble datapath.

## Test plan
- WIDTH=8, type=0, ADD, 0xC8+0x64 (200+100), dec_mode=1 -> result 0x2C, overflow=1, done 10 cycles after start, digits "  44".
- type=1, SUB, 0x05-0x0A, dec_mode=1 -> result 0xFB, overflow=0, digits "-  5".
- type=1, ADD, 0x7F+0x01, dec_mode=1 -> result 0x80, overflow=1, digits "-128".
- Pulse clear_ovf, then AND 0xF0&0x3C with dec_mode=0 -> overflow=0, result 0x30, digits "  30".
- start reasserted during CONV is ignored, with exactly one done. Reset asserted mid-CONV -> busy=0 and result=0 next cycle, and no done.
- REFRESH_BITS=2 -> activate steps 1110, 1101, 1011, 0111, 1110, holding each for 4 cycles, with LED_output matching each digit's glyph.
